// File: rtl/mcp_pkg.sv
// Shared types and constants for the Memory Card Port initiator.
// Optional watchdog is enabled with the MCP_INIT_TIMEOUT_EN macro.
package mcp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } mcp_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_WORD3 = 2'd3
    } mcp_size_t;

    localparam logic [31:0] MCP_WIN_BASE = 32'hE800_0000;
    localparam int unsigned MCP_AW       = 26;
    localparam int unsigned MCP_DW       = 8;
    localparam int unsigned MCP_TW       = 10;

    function automatic logic [MCP_DW-1:0] mcp_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [MCP_DW-1:0] r;
        case (idx)
            2'd0:    r = word[7:0];
            2'd1:    r = word[15:8];
            2'd2:    r = word[23:16];
            default: r = word[31:24];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mcp_cycle_timer.sv
// Loadable down-counter; o_done is high while the count sits at zero.
// Shared by setup, minimum-strobe and watchdog intervals.
module mcp_cycle_timer
    import mcp_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [MCP_TW-1:0] i_val,
    output logic              o_done
);

    logic [MCP_TW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/mcp_initiator.sv
// Host-side MCP initiator: splits CPU window accesses into 8-bit port cycles.
// Define MCP_INIT_TIMEOUT_EN to add the strobe watchdog and CPU_TMO reporting.
module mcp_initiator
    import mcp_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_MIN = 2
`ifdef MCP_INIT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 1023
`endif
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CPU_REQ,
    input  logic [26:0]       CPU_A,
    input  logic              CPU_WE,
    input  logic [1:0]        CPU_SIZE,
    input  logic [31:0]       CPU_DI,
    output logic [31:0]       CPU_DO,
    output logic              CPU_ACK,
    output logic              CPU_TMO,
    output logic [MCP_AW-1:0] MCP_A,
    output logic [MCP_DW-1:0] MCP_DO,
    input  logic [MCP_DW-1:0] MCP_DI,
    output logic              MCP_CSn,
    output logic              MCP_RDn,
    output logic              MCP_WRn,
    input  logic              MCP_READYn
);

    mcp_state_t        r_state, w_next;
    logic              r_wr, r_odd, r_last, r_beat;
    logic [31:0]       r_di, r_rdata;
    logic [MCP_AW-1:0] r_addr;
    logic [MCP_DW-1:0] r_mdo, w_rd_byte;
    logic              r_csn, r_rdn, r_wrn, r_ack;
    logic              w_load, w_done, w_beat_end, w_min_met, w_accept, w_odd_in, w_tmo_flag;
    logic [MCP_TW-1:0] w_load_val;
    logic [1:0]        w_rd_lane;
`ifdef MCP_INIT_TIMEOUT_EN
    logic              r_tmo_phase, r_tmo, r_cpu_tmo, w_tmo_hit, w_tmo_arm;
`endif

    mcp_cycle_timer u_timer (
        .i_clk  (CLK),
        .i_rst  (RESET),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_done (w_done)
    );

    assign w_accept  = (r_state == ST_IDLE) && CPU_REQ;
    assign w_odd_in  = (mcp_size_t'(CPU_SIZE) == SZ_BYTE) && CPU_A[0];
    assign w_rd_lane = r_beat ? 2'd2 : {1'b0, r_odd};

`ifdef MCP_INIT_TIMEOUT_EN
    // After the minimum strobe the timer is reloaded for the remaining watchdog span.
    assign w_min_met  = w_done || r_tmo_phase;
    assign w_tmo_flag = r_tmo;
`else
    assign w_min_met  = w_done;
    assign w_tmo_flag = 1'b0;
`endif

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_beat_end = 1'b0;
`ifdef MCP_INIT_TIMEOUT_EN
        w_tmo_hit  = 1'b0;
        w_tmo_arm  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (CPU_REQ) begin
                    w_next     = ST_SETUP;
                    w_load     = 1'b1;
                    w_load_val = MCP_TW'(SETUP_CYC - 1);
                end
            end
            ST_SETUP: begin
                if (w_done) begin
                    w_next     = ST_STROBE;
                    w_load     = 1'b1;
                    w_load_val = MCP_TW'(STROBE_MIN - 1);
                end
            end
            ST_STROBE: begin
                if (!MCP_READYn && w_min_met) begin
                    w_next     = ST_HOLD;
                    w_beat_end = 1'b1;
                end
`ifdef MCP_INIT_TIMEOUT_EN
                else if (w_done && r_tmo_phase) begin
                    w_next     = ST_HOLD;
                    w_beat_end = 1'b1;
                    w_tmo_hit  = 1'b1;
                end else if (w_done) begin
                    w_load     = 1'b1;
                    w_load_val = MCP_TW'(TIMEOUT_CYC - STROBE_MIN - 1);
                    w_tmo_arm  = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (r_last && !r_beat && !w_tmo_flag) begin
                    w_next     = ST_SETUP;
                    w_load     = 1'b1;
                    w_load_val = MCP_TW'(SETUP_CYC - 1);
                end else begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_byte = MCP_DI;
`ifdef MCP_INIT_TIMEOUT_EN
        if (w_tmo_hit) w_rd_byte = 8'hFF;
`endif
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_wr    <= 1'b0;
            r_odd   <= 1'b0;
            r_last  <= 1'b0;
            r_beat  <= 1'b0;
            r_di    <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_mdo   <= '0;
            r_csn   <= 1'b1;
            r_rdn   <= 1'b1;
            r_wrn   <= 1'b1;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= (w_next == ST_DONE);
            r_csn   <= !(w_next inside {ST_SETUP, ST_STROBE, ST_HOLD});
            r_rdn   <= !((w_next == ST_STROBE) && !r_wr);
            r_wrn   <= !((w_next == ST_STROBE) && r_wr);
            if (w_accept) begin
                r_wr    <= CPU_WE;
                r_odd   <= w_odd_in;
                r_last  <= CPU_SIZE[1];
                r_beat  <= 1'b0;
                r_di    <= CPU_DI;
                r_rdata <= '0;
                r_addr  <= CPU_A[26:1];
                r_mdo   <= mcp_lane(CPU_DI, {1'b0, w_odd_in});
            end
            if (w_beat_end && !r_wr) begin
                case (w_rd_lane)
                    2'd0:    r_rdata[7:0]   <= w_rd_byte;
                    2'd1:    r_rdata[15:8]  <= w_rd_byte;
                    default: r_rdata[23:16] <= w_rd_byte;
                endcase
            end
            if ((r_state == ST_HOLD) && (w_next == ST_SETUP)) begin
                r_beat <= 1'b1;
                r_addr <= r_addr + 1'b1;
                r_mdo  <= mcp_lane(r_di, 2'd2);
            end
        end
    end

`ifdef MCP_INIT_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tmo_phase <= 1'b0;
            r_tmo       <= 1'b0;
            r_cpu_tmo   <= 1'b0;
        end else begin
            r_cpu_tmo <= (w_next == ST_DONE) && r_tmo;
            if (r_state == ST_SETUP) r_tmo_phase <= 1'b0;
            else if (w_tmo_arm)      r_tmo_phase <= 1'b1;
            if (w_accept)            r_tmo <= 1'b0;
            else if (w_tmo_hit)      r_tmo <= 1'b1;
        end
    end
    assign CPU_TMO = r_cpu_tmo;
`else
    assign CPU_TMO = 1'b0;
`endif

    assign CPU_DO  = r_rdata;
    assign CPU_ACK = r_ack;
    assign MCP_A   = r_addr;
    assign MCP_DO  = r_mdo;
    assign MCP_CSn = r_csn;
    assign MCP_RDn = r_rdn;
    assign MCP_WRn = r_wrn;

endmodule

// File: tb/tb_mcp_initiator.sv
// Directed, table-driven bench for mcp_initiator with hand-computed expectations.
// The watchdog scenario runs only when MCP_INIT_TIMEOUT_EN is defined.
module tb_mcp_initiator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CPU_REQ = 1'b0;
    logic [26:0] CPU_A = '0;
    logic        CPU_WE = 1'b0;
    logic [1:0]  CPU_SIZE = '0;
    logic [31:0] CPU_DI = '0;
    logic [31:0] CPU_DO;
    logic        CPU_ACK, CPU_TMO;
    logic [25:0] MCP_A;
    logic [7:0]  MCP_DO;
    logic [7:0]  MCP_DI = '0;
    logic        MCP_CSn, MCP_RDn, MCP_WRn;
    logic        MCP_READYn = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    mcp_initiator #(
        .SETUP_CYC  (1),
        .STROBE_MIN (2)
`ifdef MCP_INIT_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(1023)
`endif
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CPU_REQ    (CPU_REQ),
        .CPU_A      (CPU_A),
        .CPU_WE     (CPU_WE),
        .CPU_SIZE   (CPU_SIZE),
        .CPU_DI     (CPU_DI),
        .CPU_DO     (CPU_DO),
        .CPU_ACK    (CPU_ACK),
        .CPU_TMO    (CPU_TMO),
        .MCP_A      (MCP_A),
        .MCP_DO     (MCP_DO),
        .MCP_DI     (MCP_DI),
        .MCP_CSn    (MCP_CSn),
        .MCP_RDn    (MCP_RDn),
        .MCP_WRn    (MCP_WRn),
        .MCP_READYn (MCP_READYn)
    );

    typedef struct {
        string       name;
        logic [26:0] a;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] di;
        int unsigned rdy;    // strobe clock from which /READY is low; 0 = tied low
        logic [7:0]  mdi;
        int unsigned lat;
        logic [31:0] dout;
        int unsigned beats;
        logic [25:0] a0, a1;
        logic [7:0]  d0, d1;
        int unsigned smax;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one CPU access; lat counts clocks from the REQ cycle through the ACK cycle (0 = no ACK).
    task automatic run_access(input logic [26:0] a, input logic we, input logic [1:0] sz,
                              input logic [31:0] di, input int unsigned rdy, input logic [7:0] mdi,
                              output int unsigned lat, output logic [31:0] dout, output logic tmo,
                              output int unsigned beats, output logic [25:0] a0, output logic [25:0] a1,
                              output logic [7:0] d0, output logic [7:0] d1, output int unsigned smax);
        int unsigned scnt, cyc;
        logic got;
        lat = 0; dout = '0; tmo = 1'b0; beats = 0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; smax = 0;
        scnt = 0; cyc = 1; got = 1'b0;
        CPU_A = a; CPU_WE = we; CPU_SIZE = sz; CPU_DI = di; MCP_DI = mdi;
        MCP_READYn = (rdy == 0) ? 1'b0 : 1'b1;
        CPU_REQ = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (!MCP_RDn || !MCP_WRn) begin
                scnt++;
                if (scnt == 1) begin
                    if (beats == 0) begin a0 = MCP_A; d0 = MCP_DO; end
                    else begin a1 = MCP_A; d1 = MCP_DO; end
                    beats++;
                end
                if (scnt > smax) smax = scnt;
                MCP_READYn = (rdy == 0 || scnt >= rdy) ? 1'b0 : 1'b1;
            end else begin
                scnt = 0;
                MCP_READYn = (rdy == 0) ? 1'b0 : 1'b1;
            end
            if (CPU_ACK) begin
                got = 1'b1;
                lat = cyc;
                dout = CPU_DO;
                tmo = CPU_TMO;
                CPU_REQ = 1'b0;
            end
        end
        CPU_REQ = 1'b0;
        MCP_READYn = 1'b1;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no CPU_ACK, expected one within 3000 clocks");
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int unsigned lat, beats, smax;
        logic [31:0] dout;
        logic        tmo, seen, got_ack;
        logic [25:0] a0, a1;
        logic [7:0]  d0, d1;

        vecs[0] = '{"byte_rd",  27'h0000004,  1'b0, 2'd0, 32'h0,         0,  8'h5A, 6,  32'h0000_005A, 1, 26'h0000002, 26'h0, 8'h00, 8'h00, 2};
        vecs[1] = '{"word_wr",  27'h0000010,  1'b1, 2'd2, 32'h1122_3344, 0,  8'h00, 10, 32'h0,         2, 26'h0000008, 26'h0000009, 8'h44, 8'h22, 2};
        vecs[2] = '{"wait_rd",  27'h0000004,  1'b0, 2'd0, 32'h0,         10, 8'h3C, 14, 32'h0000_003C, 1, 26'h0000002, 26'h0, 8'h00, 8'h00, 10};
        vecs[3] = '{"wrap_rd",  27'h7FFFFFE,  1'b0, 2'd2, 32'h0,         0,  8'hA5, 10, 32'h00A5_00A5, 2, 26'h3FFFFFF, 26'h0000000, 8'h00, 8'h00, 2};
        vecs[4] = '{"odd_rd",   27'h0000007,  1'b0, 2'd0, 32'h0,         0,  8'h81, 6,  32'h0000_8100, 1, 26'h0000003, 26'h0, 8'h00, 8'h00, 2};
        vecs[5] = '{"odd_wr",   27'h0000009,  1'b1, 2'd0, 32'hAABB_CCDD, 0,  8'h00, 6,  32'h0,         1, 26'h0000004, 26'h0, 8'hCC, 8'h00, 2};
        vecs[6] = '{"half_rd",  27'h0000020,  1'b0, 2'd1, 32'h0,         0,  8'h77, 6,  32'h0000_0077, 1, 26'h0000010, 26'h0, 8'h00, 8'h00, 2};
        vecs[7] = '{"sz3_rd",   27'h0000040,  1'b0, 2'd3, 32'h0,         0,  8'h12, 10, 32'h0012_0012, 2, 26'h0000020, 26'h0000021, 8'h00, 8'h00, 2};
        vecs[8] = '{"slow_wr",  27'h0000000,  1'b1, 2'd2, 32'h00C3_00FF, 3,  8'h00, 12, 32'h0,         2, 26'h0000000, 26'h0000001, 8'hFF, 8'hC3, 3};

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ctrl", {59'd0, MCP_CSn, MCP_RDn, MCP_WRn, CPU_ACK, CPU_TMO}, 64'b11100);
        chk("reset_data", {MCP_A, MCP_DO, CPU_DO}, 64'd0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].a, vecs[i].we, vecs[i].sz, vecs[i].di, vecs[i].rdy, vecs[i].mdi,
                       lat, dout, tmo, beats, a0, a1, d0, d1, smax);
            chk({vecs[i].name, "_lat"},   64'(lat),   64'(vecs[i].lat));
            chk({vecs[i].name, "_do"},    64'(dout),  64'(vecs[i].dout));
            chk({vecs[i].name, "_tmo"},   64'(tmo),   64'd0);
            chk({vecs[i].name, "_beats"}, 64'(beats), 64'(vecs[i].beats));
            chk({vecs[i].name, "_a0"},    64'(a0),    64'(vecs[i].a0));
            chk({vecs[i].name, "_smax"},  64'(smax),  64'(vecs[i].smax));
            if (vecs[i].beats == 2) chk({vecs[i].name, "_a1"}, 64'(a1), 64'(vecs[i].a1));
            if (vecs[i].we) begin
                chk({vecs[i].name, "_d0"}, 64'(d0), 64'(vecs[i].d0));
                if (vecs[i].beats == 2) chk({vecs[i].name, "_d1"}, 64'(d1), 64'(vecs[i].d1));
            end
        end

        // Reset in the middle of a read strobe must drop the cycle without an ACK.
        CPU_A = 27'h4; CPU_WE = 1'b0; CPU_SIZE = 2'd0; MCP_READYn = 1'b1; CPU_REQ = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge CLK);
            #1;
            if (!MCP_RDn) seen = 1'b1;
        end
        chk("abort_strobe_seen", 64'(seen), 64'd1);
        RESET = 1'b1;
        CPU_REQ = 1'b0;
        @(posedge CLK);
        #1;
        chk("abort_cs_rd", {62'd0, MCP_CSn, MCP_RDn}, 64'b11);
        RESET = 1'b0;
        got_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (CPU_ACK) got_ack = 1'b1;
        end
        chk("abort_no_ack", 64'(got_ack), 64'd0);
        run_access(27'h0000006, 1'b0, 2'd0, 32'h0, 0, 8'hE7, lat, dout, tmo, beats, a0, a1, d0, d1, smax);
        chk("post_abort_lat", 64'(lat), 64'd6);
        chk("post_abort_do",  64'(dout), 64'h0000_00E7);
        chk("post_abort_a0",  64'(a0), 64'h3);

`ifdef MCP_INIT_TIMEOUT_EN
        run_access(27'h0000004, 1'b0, 2'd0, 32'h0, 100000, 8'h5A, lat, dout, tmo, beats, a0, a1, d0, d1, smax);
        chk("tmo_flag", 64'(tmo), 64'd1);
        chk("tmo_do",   64'(dout), 64'h0000_00FF);
        chk("tmo_smax", 64'(smax), 64'd1023);
        chk("tmo_lat",  64'(lat), 64'd1027);
        run_access(27'h0000010, 1'b0, 2'd2, 32'h0, 100000, 8'h5A, lat, dout, tmo, beats, a0, a1, d0, d1, smax);
        chk("tmo_word_beats", 64'(beats), 64'd1);
        chk("tmo_word_flag",  64'(tmo), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mcp_initiator.md
# mcp_initiator

Host-side initiator for the Memory Card Port (MCP). It converts CPU accesses in the port window (E800_0000..EFFF_FFFF) into one or two 8-bit port cycles. Each cycle drives address, /CartSel and the RD/WR strobes, then waits for the responder's /READY. The block sits between the CPU bus decoder and the external or emulated card-port devices, such as the BMP backup-RAM responder.

## Interface
- SETUP_CYC, 1: clocks with address and /CartSel valid before the strobe asserts (1..15).
- STROBE_MIN, 2: minimum clocks a strobe stays asserted before /READY is honoured (1..15).
- TIMEOUT_CYC, 1023: watchdog limit in strobe clocks; only present with MCP_INIT_TIMEOUT_EN.
- CLK  in  1  system clock.
- RESET  in  1  reset; synchronous, active-high.
- CPU_REQ  in  1  request; held high until CPU_ACK.
- CPU_A  in  27  byte offset within the port window.
- CPU_WE  in  1  1 = write.
- CPU_SIZE  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- CPU_DI  in  32  write data.
- CPU_DO  out  32  read data; valid in the CPU_ACK cycle.
- CPU_ACK  out  1  one-clock completion pulse.
- CPU_TMO  out  1  high with CPU_ACK when the access timed out.
- MCP_A  out  26  port address [26:1].
- MCP_DO  out  8  write data to the port.
- MCP_DI  in  8  read data from the port.
- MCP_CSn, MCP_RDn, MCP_WRn  out  1 each  active-low selects and strobes.
- MCP_READYn  in  1  active-low cycle completion.

## Operation
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: on CPU_REQ, latch A, WE, SIZE and DI, then go to SETUP. The beat count is 2 for word and 1 otherwise.
- Address of beat n is CPU_A[26:1] + n, modulo 2^26; it wraps at the window end with no carry out.
- SETUP: CSn=0 with strobes high for SETUP_CYC clocks, then go to STROBE.
- STROBE: RDn=~WE, WRn=WE, CSn=0. Leave the state when the strobe counter reaches STROBE_MIN and MCP_READYn is 0 in the same clock. On a read, MCP_DI is captured on that clock.
- HOLD: deassert the strobe while CSn stays 0 for 1 clock.
  - If beats remain, advance the address and go to SETUP.
  - Otherwise go to DONE.
- DONE: CSn=1, CPU_ACK=1 for 1 clock, then go to IDLE. CPU_REQ sampled high in DONE is ignored; a new request is accepted in IDLE only.
- Read data placement:
  - Beat 0 goes to [7:0]; beat 1 goes to [23:16].
  - Bits [15:8] and [31:24] read 8'h00.
  - A byte read at an odd CPU_A returns the byte in [15:8] and 0 elsewhere.
- Write data: beat 0 drives DI[7:0], or DI[15:8] for an odd byte address; beat 1 drives DI[23:16].
- MCP_DO holds the current beat's data from SETUP through HOLD.

## Timing
- Reset values:
  - state = IDLE; CSn, RDn and WRn = 1.
  - MCP_A = 0, MCP_DO = 0, CPU_DO = 0.
  - CPU_ACK = 0, CPU_TMO = 0.
- RESET mid-cycle returns all strobes and CSn high in the next clock. No ACK is issued for an aborted access.
- Minimum single-beat latency, from REQ sampled to ACK, is 1 + SETUP_CYC + STROBE_MIN + 1 + 1 clocks; that is 6 with defaults.
- /READY is sampled only in STROBE. /READY low in SETUP or HOLD has no effect. /READY low from the first STROBE clock still waits for STROBE_MIN.
- All MCP outputs are registered; none is combinational from an input.

## Configuration
- MCP_INIT_TIMEOUT_EN defined: a strobe counter saturates at TIMEOUT_CYC. On reaching it, the beat completes as if /READY had arrived; read data is 8'hFF. Any remaining beats are skipped, and DONE asserts CPU_TMO with CPU_ACK.
- MCP_INIT_TIMEOUT_EN undefined: STROBE waits indefinitely, and CPU_TMO is tied to 0.

## Structure
- Package mcp_pkg:
  - state enum (mcp_state_t) and size enum (mcp_size_t).
  - Port window base constant 32'hE800_0000.
  - Width constants MCP_AW=26 and MCP_DW=8.
- Sub-module mcp_cycle_timer: loadable down-counter with a done flag. It is shared by SETUP, STROBE_MIN and timeout counting.

## Test plan
- Single-beat byte read: CPU_A=0x0000004, /READY tied low, MCP_DI=8'h5A. Expect MCP_A=0x0000002, CPU_DO=32'h0000_005A, and ACK 6 clocks after REQ.
- Word write: CPU_A=0x0000010, DI=32'h1122_3344. Expect two beats at MCP_A=0x08 then 0x09, with MCP_DO=8'h44 then 8'h22, and one ACK.
- Wait states: /READY held high 10 clocks into STROBE. Expect the strobe held exactly until /READY falls, and ACK latency 6+8=14 clocks.
- Wrap: word read at CPU_A=0x7FFFFFE. Expect the second beat at MCP_A=0x0000000.
- Timeout (MCP_INIT_TIMEOUT_EN): /READY never asserts. Expect ACK with CPU_TMO=1 after TIMEOUT_CYC strobe clocks, and CPU_DO[7:0]=8'hFF.
- RESET asserted during STROBE. Expect CSn and RDn high the next clock, no ACK, and a new REQ served normally.
